// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD time-of-day digit counters.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX       = 4'd9;
  localparam bcd_digit_t HOUR_2X_DIGIT = 4'd2;

endpackage

// File: rtl/bcd_counter_if.sv
// Control/status bundle of one BCD digit stage.
// The load/loadVal pair exists only when BCD_COUNTER_LOAD_EN is defined.
interface bcd_counter_if;
  import bcd_pkg::*;

  logic       en;
  logic       cin;
  logic       hourIs2XIn;
  bcd_digit_t cnt;
  logic       cout;
  logic       hourIs2XOut;
`ifdef BCD_COUNTER_LOAD_EN
  logic       load;
  bcd_digit_t loadVal;
`endif

  modport master (
    output en,
    output cin,
    output hourIs2XIn,
`ifdef BCD_COUNTER_LOAD_EN
    output load,
    output loadVal,
`endif
    input  cnt,
    input  cout,
    input  hourIs2XOut
  );

  modport slave (
    input  en,
    input  cin,
    input  hourIs2XIn,
`ifdef BCD_COUNTER_LOAD_EN
    input  load,
    input  loadVal,
`endif
    output cnt,
    output cout,
    output hourIs2XOut
  );

endinterface

// File: rtl/bcd_counter.sv
// One BCD digit of the time-of-day chain with combinational carry-out.
// Optional BCD_COUNTER_LOAD_EN adds a synchronous load for setting the time.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned MAX_DIGIT    = 9,
  parameter int unsigned MAX_DIGIT_2X = 3
) (
  input logic        clk,
  input logic        reset,
  bcd_counter_if.slave bus
);

  if (MAX_DIGIT > 9 || MAX_DIGIT_2X > 9) begin : g_param_err
    $error("bcd_counter: MAX_DIGIT and MAX_DIGIT_2X must be <= 9");
  end

  localparam bcd_digit_t MaxD   = bcd_digit_t'(MAX_DIGIT);
  localparam bcd_digit_t Max2xD = bcd_digit_t'(MAX_DIGIT_2X);

  bcd_digit_t cnt_q, cnt_d;
  bcd_digit_t limit;
  logic       inc;
  logic       at_limit;
  logic       ld;

`ifdef BCD_COUNTER_LOAD_EN
  bcd_digit_t ld_val;
  assign ld     = bus.load;
  assign ld_val = (bus.loadVal > BCD_MAX) ? BCD_MAX : bus.loadVal;
`else
  assign ld = 1'b0;
`endif

  assign limit    = bus.hourIs2XIn ? Max2xD : MaxD;
  assign inc      = bus.en & bus.cin;
  // >= so an out-of-range digit still wraps once the limit drops
  assign at_limit = (cnt_q >= limit);

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = at_limit ? 4'd0 : cnt_q + 4'd1;
    end
`ifdef BCD_COUNTER_LOAD_EN
    if (ld) begin
      cnt_d = ld_val;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.cnt         = cnt_q;
  assign bus.cout        = inc & at_limit & ~ld;
  assign bus.hourIs2XOut = (cnt_q == HOUR_2X_DIGIT);

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: a MAX_DIGIT=2 stage and a MAX_DIGIT=9 stage.
module tb_bcd_counter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_counter_if a_if ();
  bcd_counter_if b_if ();

  bcd_counter #(.MAX_DIGIT(2), .MAX_DIGIT_2X(3)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  bcd_counter #(.MAX_DIGIT(9), .MAX_DIGIT_2X(3)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_if.en = 1'b1; a_if.cin = 1'b1; a_if.hourIs2XIn = 1'b0;
    b_if.en = 1'b0; b_if.cin = 1'b1; b_if.hourIs2XIn = 1'b0;
`ifdef BCD_COUNTER_LOAD_EN
    a_if.load = 1'b0; a_if.loadVal = 4'd0;
    b_if.load = 1'b0; b_if.loadVal = 4'd0;
`endif
    tick(); tick();
    checks++;
    if (a_if.cnt !== 4'd0) begin
      errors++; $display("FAIL reset_a_cnt got=%0d exp=0", a_if.cnt);
    end
    checks++;
    if (b_if.cnt !== 4'd0) begin
      errors++; $display("FAIL reset_b_cnt got=%0d exp=0", b_if.cnt);
    end
    checks++;
    if (a_if.cout !== 1'b0 || a_if.hourIs2XOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_flags cout=%b h2=%b exp=0,0",
               a_if.cout, a_if.hourIs2XOut);
    end
  endtask

  task automatic test_count();
    logic [3:0] exp;
    reset = 1'b1;
    #1;
    checks++;
    if (a_if.cnt !== 4'd0 || a_if.cout !== 1'b0) begin
      errors++;
      $display("FAIL count_start cnt=%0d cout=%b exp=0,0", a_if.cnt, a_if.cout);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = 4'((i + 1) % 3);
      checks++;
      if (a_if.cnt !== exp) begin
        errors++; $display("FAIL count_cnt step=%0d got=%0d exp=%0d", i, a_if.cnt, exp);
      end
      checks++;
      if (a_if.cout !== (exp == 4'd2)) begin
        errors++; $display("FAIL count_cout step=%0d got=%b exp=%b", i, a_if.cout, exp == 4'd2);
      end
      checks++;
      if (a_if.hourIs2XOut !== (exp == 4'd2)) begin
        errors++; $display("FAIL count_h2 step=%0d got=%b exp=%b", i, a_if.hourIs2XOut, exp == 4'd2);
      end
    end
    checks++;
    if (b_if.cnt !== 4'd0) begin
      errors++; $display("FAIL count_b_hold got=%0d exp=0", b_if.cnt);
    end
  endtask

  task automatic test_hold();
    tick();
    a_if.cin = 1'b0;
    #1;
    checks++;
    if (a_if.cout !== 1'b0) begin
      errors++; $display("FAIL hold_cout got=%b exp=0", a_if.cout);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_if.cnt !== 4'd1 || a_if.cout !== 1'b0) begin
        errors++;
        $display("FAIL hold_cnt step=%0d cnt=%0d cout=%b exp=1,0", i, a_if.cnt, a_if.cout);
      end
    end
    a_if.cin = 1'b1;
    tick();
    checks++;
    if (a_if.cnt !== 4'd2 || a_if.cout !== 1'b1) begin
      errors++;
      $display("FAIL hold_resume cnt=%0d cout=%b exp=2,1", a_if.cnt, a_if.cout);
    end
    tick();
    checks++;
    if (a_if.cnt !== 4'd0) begin
      errors++; $display("FAIL hold_wrap got=%0d exp=0", a_if.cnt);
    end
  endtask

  task automatic test_enable();
    tick(); tick();
    a_if.en = 1'b0;
    #1;
    checks++;
    if (a_if.cout !== 1'b0 || a_if.hourIs2XOut !== 1'b1) begin
      errors++;
      $display("FAIL en_flags cout=%b h2=%b exp=0,1", a_if.cout, a_if.hourIs2XOut);
    end
    tick(); tick();
    checks++;
    if (a_if.cnt !== 4'd2) begin
      errors++; $display("FAIL en_hold got=%0d exp=2", a_if.cnt);
    end
    a_if.en = 1'b1;
    #1;
    checks++;
    if (a_if.cout !== 1'b1) begin
      errors++; $display("FAIL en_cout got=%b exp=1", a_if.cout);
    end
    tick();
    checks++;
    if (a_if.cnt !== 4'd0) begin
      errors++; $display("FAIL en_wrap got=%0d exp=0", a_if.cnt);
    end
    a_if.en = 1'b0;
  endtask

  task automatic test_hour2x();
    logic [3:0] exp;
    b_if.en = 1'b1; b_if.cin = 1'b1; b_if.hourIs2XIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 4'((i + 1) % 4);
      checks++;
      if (b_if.cnt !== exp || b_if.cout !== (exp == 4'd3)) begin
        errors++;
        $display("FAIL h2x_seq step=%0d cnt=%0d cout=%b exp=%0d,%b",
                 i, b_if.cnt, b_if.cout, exp, exp == 4'd3);
      end
    end
    b_if.hourIs2XIn = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (b_if.cnt !== 4'd7 || b_if.cout !== 1'b0) begin
      errors++;
      $display("FAIL h2x_seven cnt=%0d cout=%b exp=7,0", b_if.cnt, b_if.cout);
    end
    b_if.hourIs2XIn = 1'b1;
    #1;
    checks++;
    if (b_if.cout !== 1'b1) begin
      errors++; $display("FAIL h2x_recover_cout got=%b exp=1", b_if.cout);
    end
    tick();
    checks++;
    if (b_if.cnt !== 4'd0) begin
      errors++; $display("FAIL h2x_recover_cnt got=%0d exp=0", b_if.cnt);
    end
    b_if.hourIs2XIn = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (b_if.cnt !== 4'd5) begin
      errors++; $display("FAIL arst_pre got=%0d exp=5", b_if.cnt);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (b_if.cnt !== 4'd0) begin
      errors++; $display("FAIL arst_async got=%0d exp=0", b_if.cnt);
    end
    tick();
    checks++;
    if (b_if.cnt !== 4'd0) begin
      errors++; $display("FAIL arst_held got=%0d exp=0", b_if.cnt);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (b_if.cnt !== 4'd1) begin
      errors++; $display("FAIL arst_first got=%0d exp=1", b_if.cnt);
    end
    b_if.en = 1'b0;
  endtask

`ifdef BCD_COUNTER_LOAD_EN
  task automatic test_load();
    a_if.en = 1'b1; a_if.cin = 1'b1;
    tick(); tick();
    a_if.load = 1'b1; a_if.loadVal = 4'd6;
    #1;
    checks++;
    if (a_if.cout !== 1'b0) begin
      errors++; $display("FAIL load_cout got=%b exp=0", a_if.cout);
    end
    tick();
    checks++;
    if (a_if.cnt !== 4'd6) begin
      errors++; $display("FAIL load_six got=%0d exp=6", a_if.cnt);
    end
    a_if.loadVal = 4'd12;
    tick();
    checks++;
    if (a_if.cnt !== 4'd9) begin
      errors++; $display("FAIL load_clamp got=%0d exp=9", a_if.cnt);
    end
    a_if.load = 1'b0;
    #1;
    checks++;
    if (a_if.cout !== 1'b1) begin
      errors++; $display("FAIL load_oor_cout got=%b exp=1", a_if.cout);
    end
    tick();
    checks++;
    if (a_if.cnt !== 4'd0) begin
      errors++; $display("FAIL load_oor_wrap got=%0d exp=0", a_if.cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_hold();
    test_enable();
    test_hour2x();
    test_async_reset();
`ifdef BCD_COUNTER_LOAD_EN
    test_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
